aes_round_key_reader: RTL and testbench

Reader-side sequencer for the AES round key memory. It pulses the memory's init, waits for key expansion to finish, then reads every round key, in forward order for encryption or reverse order for decryption. Each key is presented on a valid/ready stream to the cipher datapath. It sits between the round key memory and the encipher/decipher round logic, and owns all round-index addressing of the key memory.

---
 rtl/aes_key_pkg.sv | 30 +++
 rtl/aes_rk_out_reg.sv | 42 ++++
 rtl/aes_round_key_reader.sv | 131 +++++++++++++
 tb/tb_aes_round_key_reader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_pkg.sv
// Shared AES key constants, reader FSM encoding and the round-key beat layout.
// Imported by the round key reader and its output holding register.
package aes_key_pkg;

   localparam logic AES_128_BIT_KEY = 1'b0;
   localparam logic AES_256_BIT_KEY = 1'b1;

   localparam logic [3:0] AES_128_NUM_ROUNDS = 4'd10;
   localparam logic [3:0] AES_256_NUM_ROUNDS = 4'd14;

   typedef enum logic [2:0] {
      RD_IDLE,
      RD_INIT,
      RD_WAIT_LOW,
      RD_WAIT_READY,
      RD_FETCH,
      RD_DONE
   } rd_state_e;

   typedef struct packed {
      logic         last;
      logic [3:0]   index;
      logic [127:0] data;
   } rk_beat_t;

   function automatic logic [3:0] num_rounds(input logic keylen);
      return (keylen == AES_256_BIT_KEY) ? AES_256_NUM_ROUNDS : AES_128_NUM_ROUNDS;
   endfunction

endpackage

// File: rtl/aes_rk_out_reg.sv
// Valid/ready holding register for one round-key beat.
// Clear wins over load; contents only change on a load, so a stalled beat stays stable.
module aes_rk_out_reg
   import aes_key_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     load,
   input  logic     clear,
   input  rk_beat_t beat_in,
   output logic     valid,
   output rk_beat_t beat_out
);

   logic     valid_d, valid_q;
   rk_beat_t beat_d, beat_q;

   always_comb begin
      valid_d = valid_q;
      beat_d  = beat_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         beat_d  = beat_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         beat_q  <= '0;
      end else begin
         valid_q <= valid_d;
         beat_q  <= beat_d;
      end
   end

   assign valid    = valid_q;
   assign beat_out = beat_q;

endmodule

// File: rtl/aes_round_key_reader.sv
// Reader-side sequencer for the AES round key memory: init, wait for expansion,
// then stream every round key forward (encrypt) or reverse (decrypt) on valid/ready.
module aes_round_key_reader
   import aes_key_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         keylen,
   input  logic         decrypt,
   output logic         busy,
   output logic         km_init,
   input  logic         km_ready,
   output logic [3:0]   km_round,
   input  logic [127:0] km_round_key,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_index,
   output logic         rk_last,
   output logic         done,
   output logic         err,
   output rd_state_e    dbg_state
);

   // rk stream: a beat transfers on a rising edge where rk_valid & rk_ready;
   // rk_valid never drops and the beat never changes until that transfer (or an abort).

   rd_state_e  state_d, state_q;
   logic [3:0] cnt_d, cnt_q;
   logic       keylen_d, keylen_q;
   logic       decrypt_d, decrypt_q;
   logic       more_d, more_q;
   logic       abort_d, abort_q;

   logic       load, clear, at_end, hs_last;
   logic [3:0] end_val;
   rk_beat_t   beat_in, beat_out;

   assign end_val = decrypt_q ? 4'd0 : num_rounds(keylen_q);
   assign at_end  = (cnt_q == end_val);
   assign hs_last = rk_valid & rk_ready & beat_out.last;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      keylen_d  = keylen_q;
      decrypt_d = decrypt_q;
      more_d    = more_q;
      abort_d   = abort_q;
      load      = 1'b0;
      clear     = 1'b0;
      case (state_q)
         RD_IDLE: begin
            if (start) begin
               keylen_d  = keylen;
               decrypt_d = decrypt;
               cnt_d     = decrypt ? num_rounds(keylen) : 4'd0;
               more_d    = 1'b1;
               abort_d   = 1'b0;
               state_d   = RD_INIT;
            end
         end
         RD_INIT:       state_d = RD_WAIT_LOW;
         // A ready still high from an earlier expansion must not start the fetch.
         RD_WAIT_LOW:   if (!km_ready) state_d = RD_WAIT_READY;
         RD_WAIT_READY: if (km_ready) state_d = RD_FETCH;
         RD_FETCH: begin
            if (!km_ready) begin
               clear   = 1'b1;
               more_d  = 1'b0;
               abort_d = 1'b1;
               state_d = RD_DONE;
            end else if (hs_last) begin
               clear   = 1'b1;
               state_d = RD_DONE;
            end else if (more_q && (!rk_valid || rk_ready)) begin
               load = 1'b1;
               // The counter parks on the final round so it never wraps.
               if (at_end) more_d = 1'b0;
               else        cnt_d  = decrypt_q ? cnt_q - 4'd1 : cnt_q + 4'd1;
            end
         end
         RD_DONE:  state_d = RD_IDLE;
         default:  state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= RD_IDLE;
         cnt_q     <= 4'd0;
         keylen_q  <= 1'b0;
         decrypt_q <= 1'b0;
         more_q    <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         keylen_q  <= keylen_d;
         decrypt_q <= decrypt_d;
         more_q    <= more_d;
         abort_q   <= abort_d;
      end
   end

   assign beat_in.last  = at_end;
   assign beat_in.index = cnt_q;
   assign beat_in.data  = km_round_key;

   aes_rk_out_reg u_out_reg (
      .clk      (clk),
      .rst      (reset),
      .load     (load),
      .clear    (clear),
      .beat_in  (beat_in),
      .valid    (rk_valid),
      .beat_out (beat_out)
   );

   assign rk_data   = beat_out.data;
   assign rk_index  = beat_out.index;
   assign rk_last   = beat_out.last;
   assign busy      = (state_q != RD_IDLE);
   assign km_init   = (state_q == RD_INIT);
   assign km_round  = (state_q == RD_FETCH) ? cnt_q : 4'd0;
   assign done      = (state_q == RD_DONE);
   assign err       = (state_q == RD_DONE) && abort_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_round_key_reader.sv
// Bench for aes_round_key_reader: a key-memory model with real AES key expansion
// feeds the reader; expected beats are queued at start and popped on each handshake.
module tb_aes_round_key_reader;
   import aes_key_pkg::*;

   logic         clk = 1'b0;
   logic         reset, start, keylen, decrypt, rk_ready;
   logic         busy, km_init, km_ready, rk_valid, rk_last, done, err;
   logic [3:0]   km_round, rk_index;
   logic [127:0] km_round_key, rk_data;
   rd_state_e    dbg_state;

   logic [127:0] rk128 [0:15];
   logic [127:0] rk256 [0:15];
   logic         mem_kl = 1'b0;
   logic         km_ready_int = 1'b0;
   logic         km_kill = 1'b0;
   logic         flush_req = 1'b0;
   int           drop_lat = 0;
   int           ready_events = 0;

   logic [132:0] exp_q[$];
   int           n_checks = 0;
   int           n_errors = 0;

   always #5 clk = ~clk;

   assign km_ready     = km_ready_int & ~km_kill;
   assign km_round_key = mem_kl ? rk256[km_round] : rk128[km_round];

   aes_round_key_reader dut (
      .clk(clk), .reset(reset), .start(start), .keylen(keylen), .decrypt(decrypt),
      .busy(busy), .km_init(km_init), .km_ready(km_ready), .km_round(km_round),
      .km_round_key(km_round_key), .rk_valid(rk_valid), .rk_ready(rk_ready),
      .rk_data(rk_data), .rk_index(rk_index), .rk_last(rk_last), .done(done),
      .err(err), .dbg_state(dbg_state)
   );

   task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // ---------------- AES key expansion reference ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] v);
      logic [7:0] inv = 8'h00;
      logic [7:0] c8;
      for (int c = 1; c < 256; c++) begin
         c8 = 8'(c);
         if (gmul(v, c8) == 8'h01) inv = c8;
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
             {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   task automatic expand(input logic kl, input logic [255:0] key);
      logic [31:0] w [0:63];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      int nk = kl ? 8 : 4;
      int nr = kl ? 14 : 10;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk == 8 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 16; r++) begin
         if (r <= nr) begin
            if (kl) rk256[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else    rk128[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         end else begin
            if (kl) rk256[r] = '0;
            else    rk128[r] = '0;
         end
      end
   endtask

   // ---------------- key memory model ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (km_init === 1'b1) begin
            repeat (drop_lat) @(negedge clk);
            km_ready_int = 1'b0;
            repeat ($urandom_range(2, 5)) @(negedge clk);
            km_ready_int = 1'b1;
            ready_events++;
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   logic [132:0] prev_beat = '0;
   logic [132:0] exp_beat;
   logic         prev_valid = 1'b0;
   logic         prev_ready = 1'b0;
   logic         expect_done = 1'b0;

   always @(negedge clk) begin
      if (reset || flush_req) begin
         exp_q.delete();
         prev_valid  = 1'b0;
         expect_done = 1'b0;
      end else begin
         if (expect_done) begin
            check_eq("done_pulse", done, 1'b1);
            check_eq("err_normal", err, 1'b0);
            expect_done = 1'b0;
         end
         if (prev_valid && !prev_ready)
            check_eq("hold_stable", {rk_valid, rk_last, rk_index, rk_data}, {1'b1, prev_beat});
         if (rk_valid && rk_ready) begin
            check_eq("beat_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               exp_beat = exp_q.pop_front();
               check_eq("beat", {rk_last, rk_index, rk_data}, exp_beat);
            end
            if (!mem_kl && rk_index == 4'd0)
               check_eq("aes128_key0", rk_data, 128'h000102030405060708090a0b0c0d0e0f);
            if (!mem_kl && rk_index == 4'd10)
               check_eq("aes128_key10", rk_data, 128'h13111d7fe3944a17f307a78b4d2b30c5);
            if (rk_last) expect_done = 1'b1;
         end
         prev_valid = rk_valid;
         prev_ready = rk_ready;
         prev_beat  = {rk_last, rk_index, rk_data};
      end
   end

   // ---------------- driver ----------------
   task automatic run_session(input logic kl, input logic dec, input int drop_l,
                              input int bp_idx, input int abort_idx, input bit do_rst);
      int nr = kl ? 14 : 10;
      int ev0, k;
      logic [3:0] idx;
      logic [3:0] last_idx = dec ? 4'd0 : 4'(nr);
      for (int i = 0; i <= nr; i++) begin
         idx = dec ? 4'(nr - i) : 4'(i);
         exp_q.push_back({idx == last_idx, idx, kl ? rk256[idx] : rk128[idx]});
      end
      mem_kl   = kl;
      drop_lat = drop_l;
      ev0      = ready_events;
      @(posedge clk); #1;
      keylen = kl; decrypt = dec; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; keylen = ~kl; decrypt = ~dec;
      check_eq("km_init_high", km_init, 1'b1);
      check_eq("busy_high", busy, 1'b1);
      @(posedge clk); #1;
      check_eq("km_init_pulse", km_init, 1'b0);
      k = 0;
      while (ready_events == ev0 && k < 100) begin
         check_eq("early_valid", rk_valid, 1'b0);
         @(posedge clk); #1;
         k++;
      end
      check_eq("ready_wait", ready_events != ev0, 1'b1);
      check_eq("fetch_lat_f", rk_valid, 1'b0);
      @(posedge clk); #1;
      check_eq("fetch_lat_f1", rk_valid, 1'b1);
      k = 0;
      while (k < 300) begin
         if (start) begin
            start = 1'b0;
            check_eq("start_ignored_init", km_init, 1'b0);
            check_eq("start_ignored_state", dbg_state, RD_FETCH);
         end
         if (done) break;
         if (abort_idx >= 0 && rk_valid && rk_index == 4'(abort_idx)) begin
            km_kill = 1'b1; flush_req = 1'b1;
            @(posedge clk); #1;
            check_eq("abort_valid", rk_valid, 1'b0);
            check_eq("abort_done", done, 1'b1);
            check_eq("abort_err", err, 1'b1);
            @(posedge clk); #1;
            check_eq("abort_done_end", {done, err, busy}, 3'b000);
            check_eq("abort_idle", dbg_state, RD_IDLE);
            km_kill = 1'b0; flush_req = 1'b0;
            return;
         end
         if (do_rst && rk_valid && rk_index == 4'd5) begin
            #2 reset = 1'b1;
            #1;
            check_eq("rst_mid_out", {rk_valid, rk_last, rk_index, rk_data}, '0);
            check_eq("rst_mid_ctl", {busy, km_init, km_round, done, err}, '0);
            repeat (2) begin @(posedge clk); #1; end
            reset = 1'b0;
            return;
         end
         if (abort_idx >= 0 && rk_valid && rk_index == 4'd2) start = 1'b1;
         if (bp_idx >= 0 && rk_valid && rk_ready && rk_index == 4'(bp_idx)) begin
            rk_ready = 1'b0;
            repeat (5) begin @(posedge clk); #1; end
            check_eq("bp_frozen_index", rk_index, 4'(bp_idx));
            rk_ready = 1'b1;
         end
         @(posedge clk); #1;
         k++;
      end
      check_eq("done_seen", done, 1'b1);
      if (bp_idx < 0) check_eq("beat_cycles", k, nr + 1);
      @(posedge clk); #1;
      check_eq("session_end", {done, busy, rk_valid}, 3'b000);
      check_eq("q_empty", exp_q.size(), 0);
   endtask

   initial begin
      logic rkl, rdec;
      reset = 1'b0; start = 1'b0; keylen = 1'b0; decrypt = 1'b0; rk_ready = 1'b1;
      expand(1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
      expand(1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
      #3 reset = 1'b1;
      #1;
      check_eq("rst_outputs", {rk_valid, rk_last, rk_index, rk_data}, '0);
      check_eq("rst_ctl", {busy, km_init, km_round, done, err}, '0);
      check_eq("rst_state", dbg_state, RD_IDLE);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      run_session(1'b0, 1'b0, 0, -1, -1, 1'b0);   // AES-128 forward
      run_session(1'b1, 1'b1, 1, -1, -1, 1'b0);   // AES-256 reverse
      run_session(1'b0, 1'b0, 2,  3, -1, 1'b0);   // backpressure at index 3
      run_session(1'b0, 1'b0, 0, -1,  6, 1'b0);   // start during FETCH, then abort at 6
      run_session(1'b1, 1'b0, 3, -1, -1, 1'b0);   // stale ready held high
      run_session(1'b0, 1'b1, 0, -1, -1, 1'b1);   // reset mid-FETCH
      check_eq("post_rst_idle", {busy, dbg_state}, {1'b0, RD_IDLE});
      run_session(1'b1, 1'b0, 1, -1, -1, 1'b0);   // full recovery session
      for (int i = 0; i < 3; i++) begin
         rkl  = 1'($urandom_range(0, 1));
         rdec = 1'($urandom_range(0, 1));
         run_session(rkl, rdec, $urandom_range(0, 3), -1, -1, 1'b0);
      end
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
